// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, latched frame config and NBits clamping.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SYNC   = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    localparam logic [4:0] NBITS_MIN = 5'd5;
    localparam logic       PAR_EVEN  = 1'b0;
    localparam logic       PAR_ODD   = 1'b1;

    typedef struct packed {
        logic [4:0] nbits;
        logic       par_en;
        logic       par_odd;
        logic       two_stop;
    } tx_cfg_t;

    // Requests below the minimum or above the data width saturate to the nearest legal size.
    function automatic logic [4:0] clamp_nbits(input logic [3:0] n, input logic [4:0] max_bits);
        logic [4:0] nw;
        nw = {1'b0, n};
        if (nw < NBITS_MIN) return NBITS_MIN;
        if (nw > max_bits)  return max_bits;
        return nw;
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side handshake, per-frame config, baud tick and serial outputs of the transmitter.
interface uart_tx_cfg_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] TxData;
    logic              TxValid;
    logic              TxReady;
    logic [3:0]        NBits;
    logic              ParityEn;
    logic              ParityOdd;
    logic              TwoStop;
    logic              Tick;
    logic              Tx;
    logic              Busy;
    logic              TxDone;

    modport master (
        output TxData, TxValid, NBits, ParityEn, ParityOdd, TwoStop, Tick,
        input  TxReady, Tx, Busy, TxDone
    );

    modport slave (
        input  TxData, TxValid, NBits, ParityEn, ParityOdd, TwoStop, Tick,
        output TxReady, Tx, Busy, TxDone
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Counts baud ticks within a bit period; bit_end fires on the tick that starts the next bit.
module uart_bit_timer #(
    parameter int OVERSAMPLE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    input  logic en,
    output logic bit_end
);
    localparam int CW = $clog2(OVERSAMPLE + 1);

    logic [CW-1:0] cnt;

    assign bit_end = en & tick & (cnt == CW'(OVERSAMPLE));

    // The clearing tick itself is the first tick of the new bit, hence the restart at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       cnt <= '0;
        else if (clear)   cnt <= CW'(1);
        else if (!en)     cnt <= '0;
        else if (bit_end) cnt <= CW'(1);
        else if (tick)    cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start, 5..DATA_W data bits LSB first, optional parity, 1 or 2 stops.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int OVERSAMPLE = 4
) (
    input logic          Clk,
    input logic          Rst_n,
    uart_tx_cfg_if.slave bus
);
    tx_state_t         state, state_n;
    tx_cfg_t           cfg, cfg_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [4:0]        idx, idx_n;
    logic              par, par_n;
    logic              stop2, stop2_n;
    logic              tx_q, tx_n;
    logic              done_q, done_n;
    logic              bit_end;

    uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .tick   (bus.Tick),
        .clear  ((state == SYNC) && bus.Tick),
        .en     ((state != IDLE) && (state != SYNC)),
        .bit_end(bit_end)
    );

    assign bus.Tx      = tx_q;
    assign bus.TxReady = (state == IDLE);
    assign bus.Busy    = (state != IDLE);
    assign bus.TxDone  = done_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state  <= IDLE;
            cfg    <= '0;
            shreg  <= '0;
            idx    <= '0;
            par    <= 1'b0;
            stop2  <= 1'b0;
            tx_q   <= 1'b1;
            done_q <= 1'b0;
        end else begin
            state  <= state_n;
            cfg    <= cfg_n;
            shreg  <= shreg_n;
            idx    <= idx_n;
            par    <= par_n;
            stop2  <= stop2_n;
            tx_q   <= tx_n;
            done_q <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cfg_n   = cfg;
        shreg_n = shreg;
        idx_n   = idx;
        par_n   = par;
        stop2_n = stop2;
        tx_n    = tx_q;
        done_n  = 1'b0;
        case (state)
            IDLE: if (bus.TxValid) begin
                cfg_n.nbits    = clamp_nbits(bus.NBits, 5'(DATA_W));
                cfg_n.par_en   = bus.ParityEn;
                cfg_n.par_odd  = bus.ParityOdd;
                cfg_n.two_stop = bus.TwoStop;
                shreg_n        = bus.TxData;
                par_n          = 1'b0;
                state_n        = SYNC;
            end
            SYNC: if (bus.Tick) begin
                tx_n    = 1'b0;
                state_n = START;
            end
            START: if (bit_end) begin
                tx_n    = shreg[0];
                par_n   = par ^ shreg[0];
                shreg_n = {1'b0, shreg[DATA_W-1:1]};
                idx_n   = '0;
                state_n = DATA;
            end
            DATA: if (bit_end) begin
                if (idx == cfg.nbits - 5'd1) begin
                    stop2_n = 1'b0;
                    if (cfg.par_en) begin
                        tx_n    = par ^ (cfg.par_odd == PAR_ODD);
                        state_n = PARITY;
                    end else begin
                        tx_n    = 1'b1;
                        state_n = STOP;
                    end
                end else begin
                    tx_n    = shreg[0];
                    par_n   = par ^ shreg[0];
                    shreg_n = {1'b0, shreg[DATA_W-1:1]};
                    idx_n   = idx + 5'd1;
                end
            end
            PARITY: if (bit_end) begin
                tx_n    = 1'b1;
                state_n = STOP;
            end
            STOP: if (bit_end) begin
                if (cfg.two_stop && !stop2) begin
                    stop2_n = 1'b1;
                end else begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed frame checks for uart_tx_cfg with OVERSAMPLE=4: line level per tick, done timing, reset abort.
module tb_uart_tx_cfg;
    localparam int DW = 8;
    localparam int OS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_W(DW)) bus();

    uart_tx_cfg #(.DATA_W(DW), .OVERSAMPLE(OS)) dut (
        .Clk  (clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Idle 'gap' cycles (line must hold), then one Tick cycle; returns at the following negedge.
    task automatic tick_once(input int gap, input logic prev);
        for (int g = 0; g < gap; g++) begin
            bus.Tick = 1'b0;
            @(negedge clk);
            chk("gap_hold", bus.Tx, prev);
        end
        bus.Tick = 1'b1;
        @(negedge clk);
        bus.Tick = 1'b0;
    endtask

    task automatic frame(input logic [7:0] data, input logic [3:0] nb_in, input logic pen,
                         input logic podd, input logic two, input int exp_nb, input logic exp_par,
                         input int exp_ticks, input bit rnd, input bit hold,
                         input logic [7:0] mid_data, input logic [3:0] mid_nb);
        logic lv [0:19];
        int   nlv;
        logic cur;
        lv[0] = 1'b0;
        for (int k = 0; k < exp_nb; k++) lv[k+1] = data[k];
        nlv = exp_nb + 1;
        if (pen) begin
            lv[nlv] = exp_par;
            nlv++;
        end
        for (int k = nlv; k < 20; k++) lv[k] = 1'b1;

        bus.TxData    = data;
        bus.NBits     = nb_in;
        bus.ParityEn  = pen;
        bus.ParityOdd = podd;
        bus.TwoStop   = two;
        bus.TxValid   = 1'b1;
        bus.Tick      = 1'b0;
        @(negedge clk);
        chk("busy_after_accept", bus.Busy, 1);
        chk("ready_after_accept", bus.TxReady, 0);
        bus.TxValid = hold;
        bus.TxData  = mid_data;
        bus.NBits   = mid_nb;

        cur = 1'b1;
        for (int i = 0; i < exp_ticks; i++) begin
            tick_once(rnd ? int'($urandom_range(0, 19)) : 0, cur);
            cur = lv[i / OS];
            chk($sformatf("tx_tick%0d_d%0h", i, data), bus.Tx, cur);
            chk($sformatf("done_early%0d", i), bus.TxDone, 0);
            chk("ready_in_frame", bus.TxReady, 0);
        end
        tick_once(rnd ? int'($urandom_range(0, 19)) : 0, cur);
        chk($sformatf("done_pulse_d%0h", data), bus.TxDone, 1);
        chk("ready_at_done", bus.TxReady, 1);
        chk("busy_at_done", bus.Busy, 0);
        chk("tx_idle_at_done", bus.Tx, 1);
        if (!hold) begin
            @(negedge clk);
            chk("done_one_cycle", bus.TxDone, 0);
        end
    endtask

    initial begin
        bus.TxData    = '0;
        bus.TxValid   = 1'b0;
        bus.NBits     = 4'd8;
        bus.ParityEn  = 1'b0;
        bus.ParityOdd = 1'b0;
        bus.TwoStop   = 1'b0;
        bus.Tick      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", bus.Tx, 1);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_done", bus.TxDone, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", bus.TxReady, 1);

        // data, nbits, pen, podd, two, eff bits, parity, ticks, rnd gaps, hold valid, mid data/nbits
        frame(8'hA5, 4'd8,  1'b0, 1'b0, 1'b0, 8, 1'b0, 40, 1'b0, 1'b0, 8'hA5, 4'd8);
        frame(8'h41, 4'd7,  1'b1, 1'b0, 1'b0, 7, 1'b0, 40, 1'b0, 1'b0, 8'h41, 4'd7);
        frame(8'h41, 4'd7,  1'b1, 1'b1, 1'b0, 7, 1'b1, 40, 1'b1, 1'b0, 8'h41, 4'd7);
        frame(8'h1F, 4'd3,  1'b0, 1'b0, 1'b1, 5, 1'b0, 32, 1'b0, 1'b0, 8'h1F, 4'd3);
        frame(8'h3C, 4'd12, 1'b0, 1'b0, 1'b0, 8, 1'b0, 40, 1'b0, 1'b0, 8'h3C, 4'd12);
        // Back-to-back with mid-frame input changes that must not disturb the first frame.
        frame(8'h5A, 4'd8,  1'b0, 1'b0, 1'b0, 8, 1'b0, 40, 1'b0, 1'b1, 8'hC3, 4'd5);
        frame(8'hC3, 4'd5,  1'b0, 1'b0, 1'b0, 5, 1'b0, 28, 1'b0, 1'b0, 8'hC3, 4'd5);
        frame(8'h96, 4'd8,  1'b1, 1'b1, 1'b0, 8, 1'b1, 44, 1'b1, 1'b0, 8'h96, 4'd8);

        // Abort a frame in DATA with reset.
        bus.TxData  = 8'h00;
        bus.NBits   = 4'd8;
        bus.ParityEn = 1'b0;
        bus.TwoStop = 1'b0;
        bus.TxValid = 1'b1;
        @(negedge clk);
        bus.TxValid = 1'b0;
        for (int i = 0; i < 10; i++) tick_once(0, 1'b0);
        chk("abort_tx_low", bus.Tx, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx_async_high", bus.Tx, 1);
        chk("abort_no_done", bus.TxDone, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_hold_done", bus.TxDone, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", bus.TxReady, 1);
        chk("abort_busy", bus.Busy, 0);
        frame(8'h0F, 4'd6,  1'b1, 1'b0, 1'b0, 6, 1'b0, 36, 1'b1, 1'b0, 8'h0F, 4'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
